// File: rtl/imuldiv_div_front_pkg.sv
// Shared definitions for the divider front end.
//   - op encodings and the op->fn / op->half-select mappings
//   - bit positions of remainder and quotient inside the 64-bit divider result
//   - divide-by-zero return values and the per-request tag layout
// Optional feature macro: IMULDIV_DIV_FRONT_DIVZERO_EN widens the tag with a
// divide-by-zero flag and the dividend.
package imuldiv_div_front_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned RESULT_W = 64;
    localparam int unsigned REM_MSB  = 63;
    localparam int unsigned REM_LSB  = 32;
    localparam int unsigned QUO_MSB  = 31;
    localparam int unsigned QUO_LSB  = 0;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_e;

    // Quotient returned for any division by zero.
    localparam logic [XLEN-1:0] DIVZERO_QUO = 32'hFFFF_FFFF;

    // Signed flavour for DIV/REM.
    function automatic logic op_is_signed(input logic [1:0] op);
        return (div_op_e'(op) == OP_DIV) || (div_op_e'(op) == OP_REM);
    endfunction

    // Remainder half selected for REM/REMU.
    function automatic logic op_sel_rem(input logic [1:0] op);
        return (div_op_e'(op) == OP_REM) || (div_op_e'(op) == OP_REMU);
    endfunction

    // Architectural result of a divide by zero.
    function automatic logic [XLEN-1:0] divzero_result(input logic            sel_rem,
                                                       input logic [XLEN-1:0] dividend);
        return sel_rem ? dividend : DIVZERO_QUO;
    endfunction

    typedef struct packed {
`ifdef IMULDIV_DIV_FRONT_DIVZERO_EN
        logic [XLEN-1:0] dividend;
        logic            dz;
`endif
        logic            sel_rem;
    } div_tag_t;

    localparam int unsigned TAG_W = $bits(div_tag_t);

endpackage

// File: rtl/imuldiv_tag_fifo.sv
// In-order tag queue: circular buffer holding one tag per outstanding request.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   push, din   : enqueue request (ignored when full, even with a same-cycle pop)
//   pop, dout   : dequeue request (ignored when empty); dout shows the head
//   full, empty : occupancy flags
module imuldiv_tag_fifo #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem_q[rd_ptr_q];

    // Pointer and occupancy update; DEPTH is a power of two so pointers wrap for free.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/imuldiv_div_front.sv
// Divider front end: forwards DIV/DIVU/REM/REMU requests to the iterative
// divider, remembers each op in an in-order tag queue, and returns the selected
// 32-bit half of the divider result through a one-entry output register.
// Ports:
//   clk, reset                     : clock, asynchronous active-high reset
//   req_*                          : pipeline request (op, dividend, divisor)
//   divreq_*                       : request to divider (combinational pass-through)
//   divresp_*                      : divider result {remainder, quotient}
//   resp_*                         : registered 32-bit result to writeback
// Optional feature macro: IMULDIV_DIV_FRONT_DIVZERO_EN returns the
// divide-by-zero values (all-ones quotient, dividend remainder) instead of the
// divider's own output.
module imuldiv_div_front
    import imuldiv_div_front_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_val,
    output logic                req_rdy,
    input  logic [1:0]          req_msg_op,
    input  logic [XLEN-1:0]     req_msg_a,
    input  logic [XLEN-1:0]     req_msg_b,
    output logic                divreq_val,
    input  logic                divreq_rdy,
    output logic                divreq_msg_fn,
    output logic [XLEN-1:0]     divreq_msg_a,
    output logic [XLEN-1:0]     divreq_msg_b,
    input  logic                divresp_val,
    output logic                divresp_rdy,
    input  logic [RESULT_W-1:0] divresp_msg_result,
    output logic                resp_val,
    input  logic                resp_rdy,
    output logic [XLEN-1:0]     resp_msg
);

    logic            full;
    logic            empty;
    logic            req_fire;
    logic            divresp_fire;
    div_tag_t        push_tag;
    div_tag_t        head_tag;
    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] result_sel;
    logic [XLEN-1:0] res_q, res_d;
    logic            res_val_q, res_val_d;

    // Issue path: pure pass-through; full gating keeps response logic off req_rdy.
    assign divreq_val    = req_val & ~full;
    assign req_rdy       = divreq_rdy & ~full;
    assign divreq_msg_fn = op_is_signed(req_msg_op);
    assign divreq_msg_a  = req_msg_a;
    assign divreq_msg_b  = req_msg_b;
    assign req_fire      = req_val & req_rdy;

    // Tag captured per issued request.
    always_comb begin
        push_tag         = '0;
        push_tag.sel_rem = op_sel_rem(req_msg_op);
`ifdef IMULDIV_DIV_FRONT_DIVZERO_EN
        push_tag.dz       = (req_msg_b == '0);
        push_tag.dividend = req_msg_a;
`endif
    end

    imuldiv_tag_fifo #(
        .WIDTH (TAG_W),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (req_fire),
        .pop   (divresp_fire),
        .din   (push_tag),
        .dout  (head_tag),
        .full  (full),
        .empty (empty)
    );

    // Response path: accept a new result whenever the output slot is free or draining.
    assign divresp_rdy  = ~res_val_q | resp_rdy;
    assign divresp_fire = divresp_val & divresp_rdy;

    assign quo = divresp_msg_result[QUO_MSB:QUO_LSB];
    assign rem = divresp_msg_result[REM_MSB:REM_LSB];

    // Half select; an orphan response (empty queue) falls back to the quotient.
    always_comb begin
        result_sel = quo;
        if (!empty) begin
            if (head_tag.sel_rem) begin
                result_sel = rem;
            end
`ifdef IMULDIV_DIV_FRONT_DIVZERO_EN
            if (head_tag.dz) begin
                result_sel = divzero_result(head_tag.sel_rem, head_tag.dividend);
            end
`endif
        end
    end

    // Output register: reload on every response, clear only on an unreplaced drain.
    always_comb begin
        res_d     = res_q;
        res_val_d = res_val_q;
        if (divresp_fire) begin
            res_d     = result_sel;
            res_val_d = 1'b1;
        end else if (res_val_q && resp_rdy) begin
            res_val_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_q     <= '0;
            res_val_q <= 1'b0;
        end else begin
            res_q     <= res_d;
            res_val_q <= res_val_d;
        end
    end

    assign resp_val = res_val_q;
    assign resp_msg = res_q;

endmodule

// File: tb/tb_imuldiv_div_front.sv
// Bench for imuldiv_div_front: behavioural divider with fixed latency, directed
// requests with hand-computed results, and a scoreboard monitor on writeback.
module tb_imuldiv_div_front;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_val;
    logic        req_rdy;
    logic [1:0]  req_msg_op;
    logic [31:0] req_msg_a;
    logic [31:0] req_msg_b;
    logic        divreq_val;
    logic        divreq_rdy;
    logic        divreq_msg_fn;
    logic [31:0] divreq_msg_a;
    logic [31:0] divreq_msg_b;
    logic        divresp_val;
    logic        divresp_rdy;
    logic [63:0] divresp_msg_result;
    logic        resp_val;
    logic        resp_rdy;
    logic [31:0] resp_msg;

    always #5 clk = ~clk;

    imuldiv_div_front #(.DEPTH(2)) dut (
        .clk                (clk),
        .reset              (reset),
        .req_val            (req_val),
        .req_rdy            (req_rdy),
        .req_msg_op         (req_msg_op),
        .req_msg_a          (req_msg_a),
        .req_msg_b          (req_msg_b),
        .divreq_val         (divreq_val),
        .divreq_rdy         (divreq_rdy),
        .divreq_msg_fn      (divreq_msg_fn),
        .divreq_msg_a       (divreq_msg_a),
        .divreq_msg_b       (divreq_msg_b),
        .divresp_val        (divresp_val),
        .divresp_rdy        (divresp_rdy),
        .divresp_msg_result (divresp_msg_result),
        .resp_val           (resp_val),
        .resp_rdy           (resp_rdy),
        .resp_msg           (resp_msg)
    );

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [31:0] exp;
        bit          care;
        string       name;
    } sb_t;
    sb_t sb[$];

    typedef struct {
        logic [63:0] res;
        int          t;
    } job_t;
    job_t divq[$];
    int   cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic fail(input string name, input string msg);
        n_checks++;
        $display("FAIL %s: %s", name, msg);
    endtask

    // Reference divider; a zero divisor yields junk so the front end's own handling shows.
    function automatic logic [63:0] div_model(input logic fn, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sbv;
        logic [31:0]        q;
        logic [31:0]        r;
        if (b == 32'd0) return 64'h0BAD_F00D_DEAD_BEEF;
        sa  = a;
        sbv = b;
        if (fn) begin
            q = 32'(sa / sbv);
            r = 32'(sa % sbv);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    // Divider: accepts every offered request, answers in order after LAT cycles.
    initial begin
        bit rf;
        bit qf;
        divresp_val        = 1'b0;
        divresp_msg_result = 64'd0;
        forever begin
            @(negedge clk);
            if (reset) begin
                divq.delete();
            end else begin
                rf = divresp_val && divresp_rdy;
                qf = divreq_val && divreq_rdy;
                if (rf && divq.size() > 0) void'(divq.pop_front());
                if (qf) divq.push_back('{res: div_model(divreq_msg_fn, divreq_msg_a, divreq_msg_b), t: cyc + LAT});
            end
            @(posedge clk);
            #1;
            cyc++;
            if (!reset && divq.size() > 0 && divq[0].t <= cyc) begin
                divresp_val        = 1'b1;
                divresp_msg_result = divq[0].res;
            end else begin
                divresp_val        = 1'b0;
                divresp_msg_result = 64'd0;
            end
        end
    end

    // Monitor: latency, ordering, hold-under-stall and stale-result checks.
    initial begin
        bit prev_fire;
        bit prev_val;
        prev_fire = 1'b0;
        prev_val  = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_fire = 1'b0;
                prev_val  = 1'b0;
            end else begin
                if (prev_fire) check("resp_val_latency", 32'(resp_val), 32'd1);
                else if (resp_val && !prev_val) fail("resp_val_rise", "resp_val rose without a divider response");
                if (resp_val) begin
                    if (sb.size() == 0) begin
                        fail("stale_resp", $sformatf("resp_msg=%h with nothing outstanding", resp_msg));
                    end else begin
                        if (sb[0].care) check(sb[0].name, resp_msg, sb[0].exp);
                        if (resp_rdy) void'(sb.pop_front());
                    end
                    if (!resp_rdy) check("divresp_rdy_stall", 32'(divresp_rdy), 32'd0);
                end
                prev_fire = divresp_val && divresp_rdy;
                prev_val  = resp_val;
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input bit care, input string name);
        bit done;
        logic fn_exp;
        done       = 1'b0;
        fn_exp     = ~op[0];
        req_val    = 1'b1;
        req_msg_op = op;
        req_msg_a  = a;
        req_msg_b  = b;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (req_val && req_rdy) begin
                check({name, "_fn"}, 32'(divreq_msg_fn), 32'(fn_exp));
                check({name, "_a"}, divreq_msg_a, a);
                check({name, "_b"}, divreq_msg_b, b);
                sb.push_back('{exp: exp, care: care, name: name});
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        req_val = 1'b0;
        if (!done) fail({name, "_issue"}, "request never accepted");
    endtask

    task automatic wait_idle(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !resp_val) done = 1'b1;
        end
        if (done) check({name, "_drained"}, 32'(sb.size()), 32'd0);
        else fail({name, "_drained"}, "responses did not drain");
        @(posedge clk);
        #1;
    endtask

    task automatic wait_resp_val(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (resp_val) done = 1'b1;
        end
        if (!done) fail({name, "_resp_val"}, "resp_val never asserted");
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset      = 1'b1;
        req_val    = 1'b0;
        req_msg_op = 2'b00;
        req_msg_a  = 32'd0;
        req_msg_b  = 32'd0;
        divreq_rdy = 1'b1;
        resp_rdy   = 1'b1;
        cycles(2);

        // Reset values and pass-through while the queue is empty.
        check("rst_resp_val", 32'(resp_val), 32'd0);
        check("rst_resp_msg", resp_msg, 32'd0);
        check("rst_divresp_rdy", 32'(divresp_rdy), 32'd1);
        check("rst_req_rdy_hi", 32'(req_rdy), 32'd1);
        req_val = 1'b1;
        #1;
        check("rst_divreq_val_hi", 32'(divreq_val), 32'd1);
        req_val = 1'b0;
        #1;
        check("rst_divreq_val_lo", 32'(divreq_val), 32'd0);
        divreq_rdy = 1'b0;
        #1;
        check("rst_req_rdy_lo", 32'(req_rdy), 32'd0);
        divreq_rdy = 1'b1;
        reset      = 1'b0;
        cycles(1);

        // Unsigned quotient/remainder.
        issue(2'b01, 32'd100, 32'd7, 32'd14, 1'b1, "divu_100_7");
        wait_idle("divu_100_7");
        issue(2'b11, 32'd100, 32'd7, 32'd2, 1'b1, "remu_100_7");
        wait_idle("remu_100_7");

        // Signed quotient/remainder with a negative dividend.
        issue(2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b1, "div_m7_2");
        wait_idle("div_m7_2");
        issue(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b1, "rem_m7_2");
        wait_idle("rem_m7_2");

        // Back-to-back fills the queue; a third request must wait.
        issue(2'b11, 32'hFFFF_FFFF, 32'd16, 32'd15, 1'b1, "remu_max_16");
        issue(2'b01, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, 1'b1, "divu_max_16");
        req_val    = 1'b1;
        req_msg_op = 2'b01;
        req_msg_a  = 32'd8;
        req_msg_b  = 32'd2;
        #1;
        check("full_count", 32'(dut.u_tag_fifo.count_q), 32'd2);
        check("full_req_rdy", 32'(req_rdy), 32'd0);
        check("full_divreq_val", 32'(divreq_val), 32'd0);
        issue(2'b01, 32'd8, 32'd2, 32'd4, 1'b1, "divu_8_2");
        wait_idle("back_to_back");

        // Writeback stall: result held, divider stalled with its second result.
        resp_rdy = 1'b0;
        issue(2'b01, 32'd50, 32'd5, 32'd10, 1'b1, "stall_divu_50_5");
        issue(2'b01, 32'd81, 32'd9, 32'd9, 1'b1, "stall_divu_81_9");
        wait_resp_val("stall");
        cycles(10);
        @(negedge clk);
        check("stall_div_held_val", 32'(divresp_val), 32'd1);
        check("stall_div_held_rdy", 32'(divresp_rdy), 32'd0);
        @(posedge clk);
        #1;
        resp_rdy = 1'b1;
        wait_idle("stall");

        // Reset with one result buffered and another in flight.
        resp_rdy = 1'b0;
        issue(2'b01, 32'd50, 32'd5, 32'd10, 1'b1, "pre_rst_divu_50_5");
        issue(2'b01, 32'd60, 32'd6, 32'd10, 1'b1, "pre_rst_divu_60_6");
        wait_resp_val("pre_rst");
        #2;
        reset = 1'b1;
        sb.delete();
        #1;
        check("midrst_resp_val", 32'(resp_val), 32'd0);
        check("midrst_resp_msg", resp_msg, 32'd0);
        check("midrst_divresp_rdy", 32'(divresp_rdy), 32'd1);
        check("midrst_req_rdy", 32'(req_rdy), 32'd1);
        cycles(2);
        reset    = 1'b0;
        resp_rdy = 1'b1;
        cycles(LAT + 4);
        issue(2'b01, 32'd9, 32'd3, 32'd3, 1'b1, "post_rst_divu_9_3");
        wait_idle("post_rst");

        // Divide by zero.
`ifdef IMULDIV_DIV_FRONT_DIVZERO_EN
        issue(2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, "div_5_0");
        wait_idle("div_5_0");
        issue(2'b10, 32'd5, 32'd0, 32'd5, 1'b1, "rem_5_0");
        wait_idle("rem_5_0");
`else
        issue(2'b00, 32'd5, 32'd0, 32'd0, 1'b0, "div_5_0");
        wait_idle("div_5_0");
        issue(2'b10, 32'd5, 32'd0, 32'd0, 1'b0, "rem_5_0");
        wait_idle("rem_5_0");
`endif

        cycles(2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/imuldiv_div_front.md
# imuldiv_div_front

Front-end and result-selection stage wrapped around the iterative divider. It accepts 32-bit DIV/DIVU/REM/REMU requests from the pipeline and issues them to the divider's request interface. It records the op of each issued request in an in-order tag queue, consumes the divider's 64-bit {remainder, quotient} response, and returns the selected 32-bit half to writeback through a one-entry registered output buffer.

## Interface

Parameters:
- DEPTH, default 2: tag-queue entries, which is the maximum number of outstanding requests; power of two, ≥2.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- req_val  in  1  pipeline request valid.
- req_rdy  out  1  pipeline request ready.
- req_msg_op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
- req_msg_a  in  32  dividend.
- req_msg_b  in  32  divisor.
- divreq_val  out  1  request valid to divider.
- divreq_rdy  in  1  divider ready.
- divreq_msg_fn  out  1  1 = signed (DIV/REM), 0 = unsigned.
- divreq_msg_a  out  32  equals req_msg_a.
- divreq_msg_b  out  32  equals req_msg_b.
- divresp_val  in  1  divider result valid.
- divresp_rdy  out  1  ready to divider.
- divresp_msg_result  in  64  [63:32] remainder, [31:0] quotient.
- resp_val  out  1  result valid to writeback.
- resp_rdy  in  1  writeback ready.
- resp_msg  out  32  selected result.

## Operation

- Issue path is combinational pass-through. The unit does not register requests.
  - full = (count == DEPTH).
  - divreq_val = req_val & !full.
  - req_rdy = divreq_rdy & !full.
  - divreq_msg_fn = !req_msg_op[0].
- Issue fires when req_val & req_rdy. On issue, push tag {op[1]} into the queue (op[1]=1 selects the remainder).
- Response path:
  - divresp_rdy = !buf_val | resp_rdy.
  - Response fires when divresp_val & divresp_rdy. On fire, pop the head tag and load buf with the remainder if tag=1, otherwise the quotient. Set buf_val.
- Output: resp_val = buf_val, resp_msg = buf.
  - buf_val clears when resp_val & resp_rdy and no response fires in the same cycle.
  - When both fire in the same cycle, buf reloads and buf_val stays 1 (full throughput).
- Queue:
  - Circular buffer with write pointer, read pointer and a count of width clog2(DEPTH)+1.
  - Pointers wrap modulo DEPTH.
  - Push and pop in the same cycle leave count unchanged.
  - When full, push is blocked even if a pop occurs in the same cycle. This keeps the req_rdy path free of response-side logic.
- A divider response arriving with the queue empty is a protocol error. The queue must not underflow; the response is still consumed, with the quotient selected.
- Reset, including mid-operation: count, pointers and buf_val go to 0 and buf goes to 0. In-flight tags are discarded. The divider shares this reset, so no stale response arrives.

## Timing

- Reset values: resp_val=0, resp_msg=0, divresp_rdy=1.
  - req_rdy follows divreq_rdy because the queue is empty.
  - divreq_val follows req_val.
- Issue adds zero cycles.
- Response adds one cycle: divresp fire in cycle N gives resp_val=1 in cycle N+1.
- End-to-end latency = divider latency + 1.
- resp_msg is held stable while resp_val & !resp_rdy.
- Backpressure: while buf_val & !resp_rdy, divresp_rdy=0, which stalls the divider.
- Queue full: req_rdy=0 and divreq_val=0 regardless of divreq_rdy.

## Configuration

- Macro: IMULDIV_DIV_FRONT_DIVZERO_EN.
- Defined:
  - Each tag also carries a divide-by-zero flag (req_msg_b==0) and the 32-bit dividend.
  - At response, the divider's result is discarded and the RISC-style values are returned:
    - DIV/DIVU → 0xFFFFFFFF.
    - REM/REMU → dividend.
  - The divider is still issued the request, which preserves ordering and handshake timing.
- Undefined:
  - Tag is 1 bit.
  - Divide-by-zero results are whatever the divider produces.

## Structure

- Shared package/header:
  - op encodings (DIV, DIVU, REM, REMU);
  - the op→fn mapping;
  - the op→half-select mapping;
  - result field positions in the 64-bit response (REM_MSB=63, REM_LSB=32, QUO_MSB=31);
  - the divide-by-zero constants.
- One sub-module: imuldiv_tag_fifo.
  - Parameterised width and depth.
  - Ports: push, pop, din, dout, full, empty.
  - Asynchronous active-high reset.
- Top level holds handshake logic, the select mux and the output buffer.

## Test plan

- DIVU a=100, b=7 → resp_msg=14. REMU with the same operands → 2. resp_val rises exactly 1 cycle after divresp fire.
- DIV a=0xFFFFFFF9 (−7), b=2 → 0xFFFFFFFD. REM with the same operands → 0xFFFFFFFF.
- Back-to-back REMU 0xFFFFFFFF/16 then DIVU 0xFFFFFFFF/16 → 15 then 0x0FFFFFFF, in order. Queue count peaks at 2 and req_rdy=0 while full.
- resp_rdy held low for 10 cycles after resp_val → resp_msg stable, divresp_rdy=0, the divider's second result is held. On release, both results drain in order.
- Reset asserted mid-division, then DIVU 9/3 → resp_msg=3. No stale result appears, and all outputs take their reset values immediately.
- With IMULDIV_DIV_FRONT_DIVZERO_EN: DIV 5/0 → 0xFFFFFFFF and REM 5/0 → 5. Without the macro, the bench checks only that the response handshake completes.
